// File: rtl/dot_product_sequencer.sv
// Feeder for a pipelined signed MAC: loads vectors A and B from a valid/ready word
// stream, streams the element pairs into a freshly cleared MAC, counts MAC result
// pulses to find the final accumulator value, and offers it on a valid/ready port.
`timescale 1ns/1ps

module dot_product_sequencer #(
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned ACC_WIDTH = 28,
    parameter int unsigned N         = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [WIDTH-1:0]     s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic signed [WIDTH-1:0]     mac_a,
    output logic signed [WIDTH-1:0]     mac_b,
    output logic                        mac_valid_in,
    output logic                        mac_reset,
    input  logic signed [ACC_WIDTH-1:0] mac_f,
    input  logic                        mac_valid_out,
    output logic signed [ACC_WIDTH-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CntW = $clog2(N + 1);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(N);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StClear,
        StStream,
        StDrain,
        StOutput
    } state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic [CntW-1:0]         pulse_cnt_q;
    logic signed [WIDTH-1:0] vec_a_q [N];
    logic signed [WIDTH-1:0] vec_b_q [N];

    logic            s_fire;
    logic            m_fire;
    logic [IdxW-1:0] idx_next;
    logic            pulse_count_en;
    logic            pulse_done;

    assign s_fire   = s_valid & s_ready;
    assign m_fire   = m_valid & m_ready;
    assign idx_next = idx_q + IdxW'(1);

    // MAC result pulses are counted from the first STREAM cycle; the count saturates at N.
    assign pulse_count_en = mac_valid_out && (pulse_cnt_q != CntFull) &&
                            ((state_q == StStream) || (state_q == StDrain));

    // Last result is either arriving now or already arrived during STREAM (zero-latency MAC).
    assign pulse_done = (pulse_cnt_q == CntFull) ||
                        (mac_valid_out && (pulse_cnt_q == CntLast));

    // MAC is flushed during our own reset and for the single CLEAR cycle of every job.
    assign mac_reset = reset | (state_q == StClear);

    // Sequencer FSM with registered handshake and MAC-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLoadA;
            idx_q        <= '0;
            pulse_cnt_q  <= '0;
            s_ready      <= 1'b0;
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
        end else begin
            if (pulse_count_en) begin
                pulse_cnt_q <= pulse_cnt_q + CntW'(1);
            end

            unique case (state_q)
                StLoadA: begin
                    // Covers the first cycle after reset, where s_ready is still low.
                    s_ready <= 1'b1;
                    if (s_fire) begin
                        vec_a_q[idx_q] <= s_data;
                        if (idx_q == IdxLast) begin
                            idx_q   <= '0;
                            state_q <= StLoadB;
                        end else begin
                            idx_q <= idx_next;
                        end
                    end
                end

                StLoadB: begin
                    if (s_fire) begin
                        vec_b_q[idx_q] <= s_data;
                        if (idx_q == IdxLast) begin
                            idx_q   <= '0;
                            s_ready <= 1'b0;
                            state_q <= StClear;
                        end else begin
                            idx_q <= idx_next;
                        end
                    end
                end

                StClear: begin
                    // Present element 0 so the first STREAM cycle already carries valid data.
                    pulse_cnt_q  <= '0;
                    idx_q        <= '0;
                    mac_valid_in <= 1'b1;
                    mac_a        <= vec_a_q[0];
                    mac_b        <= vec_b_q[0];
                    state_q      <= StStream;
                end

                StStream: begin
                    if (idx_q == IdxLast) begin
                        idx_q        <= '0;
                        mac_valid_in <= 1'b0;
                        mac_a        <= '0;
                        mac_b        <= '0;
                        state_q      <= StDrain;
                    end else begin
                        idx_q <= idx_next;
                        mac_a <= vec_a_q[idx_next];
                        mac_b <= vec_b_q[idx_next];
                    end
                end

                StDrain: begin
                    if (pulse_done) begin
                        m_data  <= mac_f;
                        m_valid <= 1'b1;
                        state_q <= StOutput;
                    end
                end

                StOutput: begin
                    if (m_fire) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state_q <= StLoadA;
                    end
                end

                default: begin
                    state_q <= StLoadA;
                end
            endcase
        end
    end

endmodule
